// File: rtl/jt900h_muldiv.sv
// jt900h_muldiv: iterative shift-add multiply / restoring divide, one result bit per cen cycle.
// Define JT900H_MULDIV_EARLY_EN to let multiplies exit once the remaining multiplier bits are zero.
module jt900h_muldiv #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           start,
  input  logic           div,
  input  logic           sgn,
  input  logic           bs,
  input  logic [2*W-1:0] op0,
  input  logic [W-1:0]   op1,
  output logic           busy,
  output logic           done,
  output logic           v,
  output logic [2*W-1:0] rslt
);
  localparam int H = W / 2;
  localparam int CW = $clog2(W);
`ifdef JT900H_MULDIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, PREP, ITER} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, sgn_q, sgn_d, bs_q, bs_d, neg_q, neg_d, rneg_q, rneg_d;
  logic busy_q, busy_d, done_q, done_d, v_q, v_d;
  logic [2*W-1:0] a_q, a_d, acc_q, acc_d, sh_q, sh_d, rslt_q, rslt_d;
  logic [W-1:0] b_q, b_d, m_q, m_d;
  logic [W-1:0] mn, amag, bmag, dhi, tr, q, r, qf, rf, qlim;
  logic [2*W-1:0] m2, dmag, acc_n, src, p, res;
  logic [W:0] t;
  logic sa, sd, sb, dov, ge, ovf, fin;
  always_comb begin
    mn = bs_q ? {{H{1'b0}}, {H{1'b1}}} : '1;
    m2 = bs_q ? {{W{1'b0}}, {W{1'b1}}} : '1;
    sa = sgn_q & (bs_q ? a_q[H-1] : a_q[W-1]);
    sd = sgn_q & (bs_q ? a_q[W-1] : a_q[2*W-1]);
    sb = sgn_q & (bs_q ? b_q[H-1] : b_q[W-1]);
    amag = (sa ? -a_q[W-1:0] : a_q[W-1:0]) & mn;
    bmag = (sb ? -b_q : b_q) & mn;
    dmag = (sd ? -a_q : a_q) & m2;
    dhi = bs_q ? {{H{1'b0}}, dmag[W-1:H]} : dmag[2*W-1:W];
    dov = div_q & (bmag == '0 || dhi >= bmag);
    t = {acc_q[2*W-1:W], acc_q[W-1]};
    ge = t >= {1'b0, m_q};
    tr = ge ? t[W-1:0] - m_q : t[W-1:0];
    acc_n = div_q ? {tr, acc_q[W-2:0], ge} : acc_q + (m_q[0] ? sh_q : '0);
    // Sign fix-up and overflow check are applied on the exit edge so done lands at N+2
    src = st_q == ITER ? acc_n : '0;
    q = src[W-1:0] & mn;
    r = src[2*W-1:W] & mn;
    qlim = (mn >> 1) + W'(neg_q);
    qf = (neg_q ? -q : q) & mn;
    rf = (rneg_q ? -r : r) & mn;
    p = src & m2;
    ovf = st_q == PREP ? dov : div_q & sgn_q & (q > qlim);
    res = ovf ? a_q & m2 : !div_q ? (neg_q ? -p : p) & m2 :
          bs_q ? {{W{1'b0}}, rf[H-1:0], qf[H-1:0]} : {rf, qf};
    fin = st_q == PREP ? dov | (EARLY && !div_q && bmag == '0) :
          cnt_q == '0 || (EARLY && !div_q && m_q[W-1:1] == '0);
    st_d = st_q;
    cnt_d = cnt_q;
    div_d = div_q;
    sgn_d = sgn_q;
    bs_d = bs_q;
    a_d = a_q;
    b_d = b_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    acc_d = acc_q;
    sh_d = sh_q;
    m_d = m_q;
    busy_d = busy_q;
    done_d = 1'b0;
    v_d = v_q;
    rslt_d = rslt_q;
    if (st_q == IDLE && start) begin
      div_d = div;
      sgn_d = sgn;
      bs_d = bs;
      a_d = op0;
      b_d = op1;
      busy_d = 1'b1;
      st_d = PREP;
    end else if (st_q != IDLE && fin) begin
      st_d = IDLE;
      busy_d = 1'b0;
      done_d = 1'b1;
      v_d = ovf;
      rslt_d = res;
    end else if (st_q == PREP) begin
      st_d = ITER;
      cnt_d = CW'(bs_q ? H - 1 : W - 1);
      neg_d = div_q ? sd ^ sb : sa ^ sb;
      rneg_d = sd;
      acc_d = div_q ? {dhi, bs_q ? {dmag[H-1:0], {H{1'b0}}} : dmag[W-1:0]} : '0;
      sh_d = {{W{1'b0}}, amag};
      m_d = bmag;
    end else if (st_q == ITER) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = acc_n;
      sh_d = sh_q << 1;
      m_d = div_q ? m_q : m_q >> 1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      div_q <= 1'b0;
      sgn_q <= 1'b0;
      bs_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      acc_q <= '0;
      sh_q <= '0;
      m_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      v_q <= 1'b0;
      rslt_q <= '0;
    end else if (cen) begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      sgn_q <= sgn_d;
      bs_q <= bs_d;
      a_q <= a_d;
      b_q <= b_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      acc_q <= acc_d;
      sh_q <= sh_d;
      m_q <= m_d;
      busy_q <= busy_d;
      done_q <= done_d;
      v_q <= v_d;
      rslt_q <= rslt_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign v = v_q;
  assign rslt = rslt_q;
endmodule

// File: tb/tb_jt900h_muldiv.sv
// tb_jt900h_muldiv: scoreboard bench for jt900h_muldiv (W=16).
module tb_jt900h_muldiv;
  typedef struct {logic [31:0] r; logic v; int lat;} exp_t;
  typedef struct {bit d; bit s; bit b; logic [31:0] a; logic [15:0] c; logic [31:0] r; logic v;} op_t;
  logic clk = 1'b0, rst = 1'b1, cen = 1'b1, start = 1'b0, div = 1'b0, sgn = 1'b0, bs = 1'b0;
  logic [31:0] op0 = '0;
  logic [15:0] op1 = '0;
  logic busy, done, v;
  logic [31:0] rslt;
  exp_t sbq[$];
  int n_cmp = 0, n_err = 0;

  jt900h_muldiv #(.W(16)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .div(div), .sgn(sgn), .bs(bs),
    .op0(op0), .op1(op1), .busy(busy), .done(done), .v(v), .rslt(rslt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input op_t o);
    exp_t e;
    int n;
    longint x, y, ax, ay, q, rm, mn, m2;
    n = o.b ? 8 : 16;
    mn = (longint'(1) << n) - 1;
    m2 = (longint'(1) << (2 * n)) - 1;
    e.r = '0;
    e.v = 1'b0;
    e.lat = n + 2;
    if (!o.d) begin
      x = longint'(o.a) & mn;
      y = longint'(o.c) & mn;
      if (o.s && x[n-1]) x -= mn + 1;
      if (o.s && y[n-1]) y -= mn + 1;
      e.r = 32'((x * y) & m2);
`ifdef JT900H_MULDIV_EARLY_EN
      ay = y < 0 ? -y : y;
      e.lat = 2;
      for (int k = 0; k < n; k++) if (ay[k]) e.lat = k + 3;
`endif
    end else begin
      x = longint'(o.a) & m2;
      y = longint'(o.c) & mn;
      if (o.s && x[2*n-1]) x -= m2 + 1;
      if (o.s && y[n-1]) y -= mn + 1;
      ax = x < 0 ? -x : x;
      ay = y < 0 ? -y : y;
      if (y == 0 || (ax >> n) >= ay) begin
        e.v = 1'b1;
        e.lat = 2;
      end else begin
        q = x / y;
        rm = x % y;
        if (o.s && (q > (mn >> 1) || q < -((mn >> 1) + 1))) e.v = 1'b1;
        else e.r = 32'(((rm & mn) << n) | (q & mn));
      end
      if (e.v) e.r = 32'(longint'(o.a) & m2);
    end
    return e;
  endfunction

  task automatic issue(input op_t o);
    exp_t e;
    e = model(o);
    e.r = o.r;
    e.v = o.v;
    sbq.push_back(e);
    div = o.d; sgn = o.s; bs = o.b; op0 = o.a; op1 = o.c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int stall_at, input int stall_len, input int junk_at, output int lat, output int bc);
    lat = 1;
    bc = 0;
    while (!done && lat < 60) begin
      bc += int'(busy);
      if (lat == junk_at) begin start = 1'b1; div = 1'b0; op0 = 32'hFFFF_FFFF; op1 = 16'h0001; end
      if (lat == stall_at) cen = 1'b0;
      if (lat == stall_at + stall_len) cen = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({busy, done, v, rslt} !== 35'b0) begin
      n_err++;
      $display("FAIL reset got busy=%b done=%b v=%b rslt=%h want all zero", busy, done, v, rslt);
    end
  endtask

  task automatic test_directed;
    op_t t[8];
    exp_t e;
    int lat, bc;
    t = '{'{1'b0, 1'b0, 1'b0, 32'h0000_1234, 16'h0100, 32'h0012_3400, 1'b0},
          '{1'b0, 1'b1, 1'b1, 32'h0000_00FE, 16'h0003, 32'h0000_FFFA, 1'b0},
          '{1'b1, 1'b0, 1'b0, 32'h0001_0005, 16'h0002, 32'h0001_8002, 1'b0},
          '{1'b1, 1'b1, 1'b1, 32'h0000_FFF9, 16'h0002, 32'h0000_FFFD, 1'b0},
          '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 16'h0000, 32'hDEAD_BEEF, 1'b1},
          '{1'b1, 1'b1, 1'b1, 32'h0000_FF80, 16'h00FF, 32'h0000_FF80, 1'b1},
          '{1'b1, 1'b1, 1'b1, 32'h0000_FF80, 16'h0001, 32'h0000_0080, 1'b0},
          '{1'b1, 1'b0, 1'b0, 32'h0005_0000, 16'h0005, 32'h0005_0000, 1'b1}};
    foreach (t[i]) begin
      issue(t[i]);
      wait_done(-1, 0, -1, lat, bc);
      e = sbq.pop_front();
      n_cmp++;
      if (rslt !== e.r) begin n_err++; $display("FAIL directed[%0d] rslt got %h want %h", i, rslt, e.r); end
      n_cmp++;
      if (v !== e.v) begin n_err++; $display("FAIL directed[%0d] v got %b want %b", i, v, e.v); end
      n_cmp++;
      if (lat != e.lat || bc != e.lat - 1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL directed[%0d] timing got lat=%0d busy_cycles=%0d busy=%b want lat=%0d busy_cycles=%0d busy=0",
                 i, lat, bc, busy, e.lat, e.lat - 1);
      end
    end
  endtask

  task automatic test_busy_start;
    exp_t e;
    int lat, bc;
    issue('{1'b0, 1'b0, 1'b0, 32'h0000_1234, 16'h0100, 32'h0012_3400, 1'b0});
    wait_done(-1, 0, 4, lat, bc);
    e = sbq.pop_front();
    n_cmp++;
    if (rslt !== e.r || lat != e.lat) begin
      n_err++;
      $display("FAIL busy_start got rslt=%h lat=%0d want rslt=%h lat=%0d", rslt, lat, e.r, e.lat);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_cen_stall;
    exp_t e;
    int lat, bc;
    issue('{1'b1, 1'b0, 1'b0, 32'h0001_0005, 16'h0002, 32'h0001_8002, 1'b0});
    wait_done(5, 3, -1, lat, bc);
    e = sbq.pop_front();
    n_cmp++;
    if (rslt !== e.r || v !== e.v) begin
      n_err++;
      $display("FAIL cen_stall result got rslt=%h v=%b want rslt=%h v=%b", rslt, v, e.r, e.v);
    end
    n_cmp++;
    if (lat != e.lat + 3) begin n_err++; $display("FAIL cen_stall latency got %0d want %0d", lat, e.lat + 3); end
  endtask

  task automatic test_back_to_back;
    op_t t[2];
    exp_t e;
    int lat, bc;
    t = '{'{1'b1, 1'b1, 1'b1, 32'h0000_FFF9, 16'h0002, 32'h0000_FFFD, 1'b0},
          '{1'b0, 1'b1, 1'b1, 32'h0000_00FE, 16'h0003, 32'h0000_FFFA, 1'b0}};
    issue(t[0]);
    foreach (t[i]) begin
      wait_done(-1, 0, -1, lat, bc);
      e = sbq.pop_front();
      n_cmp++;
      if (rslt !== e.r || v !== e.v || lat != e.lat) begin
        n_err++;
        $display("FAIL back_to_back[%0d] got rslt=%h v=%b lat=%0d want rslt=%h v=%b lat=%0d", i, rslt, v, lat, e.r, e.v, e.lat);
      end
      if (i == 0) issue(t[1]);
    end
  endtask

  task automatic test_rst_mid;
    int pulses;
    issue('{1'b1, 1'b0, 1'b0, 32'h0001_0005, 16'h0002, 32'h0001_8002, 1'b0});
    void'(sbq.pop_front());
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, v, rslt} !== 35'b0) begin
      n_err++;
      $display("FAIL rst_mid got busy=%b done=%b v=%b rslt=%h want all zero", busy, done, v, rslt);
    end
    pulses = 0;
    repeat (25) begin @(posedge clk); #1; pulses += int'(done); end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d done pulses want 0", pulses); end
  endtask

  task automatic test_random;
    op_t o;
    exp_t e, m;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      o.d = 1'($urandom);
      o.s = 1'($urandom);
      o.b = 1'($urandom);
      o.a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFF);
      o.c = 16'($urandom);
      m = model(o);
      o.r = m.r;
      o.v = m.v;
      issue(o);
      wait_done(-1, 0, -1, lat, bc);
      e = sbq.pop_front();
      n_cmp++;
      if (rslt !== e.r || v !== e.v || lat != e.lat) begin
        n_err++;
        $display("FAIL random[%0d] d=%b s=%b b=%b a=%h c=%h got rslt=%h v=%b lat=%0d want rslt=%h v=%b lat=%0d",
                 i, o.d, o.s, o.b, o.a, o.c, rslt, v, lat, e.r, e.v, e.lat);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_directed();
    test_busy_start();
    test_cen_stall();
    test_back_to_back();
    test_rst_mid();
    test_random();
    n_cmp++;
    if (sbq.size() != 0) begin n_err++; $display("FAIL scoreboard_empty got %0d entries want 0", sbq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jt900h_muldiv.md
Name: jt900h_muldiv

Overview:
- Parametrised iterative multiply/divide unit; the sequential companion to the combinational ALU in the jt900h execution unit.
- Implements the MUL, MULS, DIV and DIVS instructions.
- Computes one result bit per enabled clock cycle, using shift-add for multiplication and restoring division for division.
- The sequencer starts it with a one-cycle start pulse and waits for done.

Parameters:
W, 16, full operand width (must be even, >=8); byte mode operates on N=W/2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cen  in  1  clock enable; all state advances only when cen=1
start  in  1  request; sampled only in IDLE with cen=1
div  in  1  0=multiply, 1=divide
sgn  in  1  1=signed (MULS/DIVS), 0=unsigned
bs  in  1  byte mode: N=W/2 instead of N=W
op0  in  2W  multiplicand (low N bits) / dividend (low 2N bits)
op1  in  W  multiplier / divisor (low N bits used)
busy  out  1  operation in progress
done  out  1  one-cen-cycle completion pulse
v  out  1  overflow: divide by zero or quotient overflow
rslt  out  2W  product or {remainder,quotient}; bits above 2N are zero

Behaviour:
- Reset: the block is in IDLE with busy=0, done=0, v=0 and rslt=0. A reset mid-operation aborts it immediately with the same values, and no done pulse is produced.
- cen=0 freezes all registers and outputs.
- At acceptance (start=1, IDLE, cen=1), latch div, sgn, bs, op0 and op1, then go to PREP. busy=1 from the next cycle until done.
- A start while not in IDLE is ignored.
- start is accepted in the same cycle that done=1, because the block is already in IDLE then.
- States:
  - IDLE
  - PREP: take operand magnitudes when sgn=1 and record result signs. Check the early-overflow cases; if one hits, go to FIX, otherwise load the counter with N-1 and go to ITER.
  - ITER: one bit per cycle. Leave when counter=0.
  - FIX: negate the results according to the signs and run the signed overflow check.
  - DONE→IDLE: the FIX→IDLE transition registers rslt and v and pulses done=1 for one cen cycle; busy drops in the same cycle.
- Latency: done=1 exactly N+2 cen cycles after the acceptance cycle. On the early-overflow path this is 2 cycles.
- Multiply: rslt[2N-1:0] = op0[N-1:0]*op1[N-1:0], as two's complement when sgn=1; v=0.
- Divide:
  - Dividend is op0[2N-1:0], divisor is op1[N-1:0].
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - rslt[N-1:0] = quotient, rslt[2N-1:N] = remainder.
- Early overflow, detected in PREP:
  - divisor == 0;
  - unsigned mode with dividend[2N-1:N] >= divisor;
  - signed mode with |dividend|[2N-1:N] >= |divisor|.
- Signed quotient overflow, detected in FIX: a positive quotient > 2^(N-1)-1, or a negative quotient magnitude > 2^(N-1).
- On any overflow: v=1 and rslt = op0 as latched, zero-extended above 2N bits, i.e. the register is left unchanged.
- rslt and v hold their values until the next done.

Optional Feature:
JT900H_MULDIV_EARLY_EN:
- Defined: for multiply, ITER exits to FIX as soon as the remaining unshifted multiplier bits are all zero. done then follows 1 cycle after FIX, and latency is variable between 2 and N+2. Division is unchanged.
- Undefined: fixed latency N+2 for every operation.
- Results are identical either way.

Test Plan:
- Unsigned word multiply (W=16, bs=0, sgn=0, div=0), op0=0x1234, op1=0x0100 -> rslt=0x00123400, v=0; busy is high cycles 1..17 and done=1 at cycle 18.
- Signed byte multiply, op0[7:0]=0xFE, op1=0x0003, bs=1, sgn=1 -> rslt=0x0000FFFA, done at cycle 10.
- Unsigned word divide, op0=0x00010005, op1=0x0002 -> rslt=0x00018002 (q=0x8002, r=1), v=0.
- Signed byte divide, op0=0x0000FFF9 (-7), op1=0x0002 -> rslt=0x0000FFFD (q=0xFD, r=0xFF), v=0.
- Overflow cases:
  - op1=0 with op0=0xDEADBEEF -> v=1, rslt=0xDEADBEEF, done at cycle 2.
  - Signed byte op0=0xFF80, op1=0x00FF (-128/-1) -> v=1, rslt=0x0000FF80.
- Control corner cases:
  - A start pulse while busy is ignored.
  - rst asserted at cycle 5 of a word divide gives busy=0, done=0, rslt=0, v=0 on the next cycle.
  - Holding cen=0 for 3 cycles mid-ITER delays done by exactly 3 cycles.
  - A back-to-back start in the done cycle is accepted.
